// File: rtl/bottleneck_pass_sched.sv
// Pass sequencer for the residual bottleneck stage: steers the shared weight stream
// to the five conv weight ports, drives the feedback/shortcut selects and tracks adder beats.
module bottleneck_pass_sched #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_PASS     = 3,
    parameter int PXL_PER_PASS = 36864,
    parameter int W1_NUM       = 4096,
    parameter int W2_NUM       = 36864,
    parameter int W3_NUM       = 16384,
    parameter int W4_NUM       = 16384,
    parameter int W5_NUM       = 16384,
    localparam int PW          = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [PW-1:0]         pass_idx,
    input  logic                  valid_weight_in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    output logic                  weight_ready,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  valid_weight_out1,
    output logic                  valid_weight_out2,
    output logic                  valid_weight_out3,
    output logic                  valid_weight_out4,
    output logic                  valid_weight_out5,
    output logic                  src_ready,
    output logic                  sel_feedback,
    output logic                  sel_shortcut,
    input  logic                  valid_add,
    output logic                  last_pass_valid,
    output logic                  err
);

    // state | meaning
    // IDLE  | waiting for start
    // LOAD  | streaming weights to the conv ports of the current pass
    // RUN   | counting adder output beats of the current pass
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    localparam int W_MAX_A = (W1_NUM > W2_NUM) ? W1_NUM : W2_NUM;
    localparam int W_MAX_B = (W3_NUM > W4_NUM) ? W3_NUM : W4_NUM;
    localparam int W_MAX_C = (W_MAX_A > W_MAX_B) ? W_MAX_A : W_MAX_B;
    localparam int W_MAX   = (W_MAX_C > W5_NUM) ? W_MAX_C : W5_NUM;
    localparam int WW      = (W_MAX > 1) ? $clog2(W_MAX) : 1;
    localparam int PCW     = (PXL_PER_PASS > 1) ? $clog2(PXL_PER_PASS) : 1;

    localparam logic [PW-1:0]  PASS_LAST = PW'(NUM_PASS - 1);
    localparam logic [PCW-1:0] PCNT_LAST = PCW'(PXL_PER_PASS - 1);

    state_t         state;
    logic [1:0]     ptr;
    logic [WW-1:0]  wcnt;
    logic [PCW-1:0] pcnt;
    logic [2:0]     cur_port;
    logic           last_port;
    logic [WW-1:0]  wlast;
    logic           accept;

    // Pass 0 loads conv1, conv4, conv2, conv3; later passes load conv5, conv2, conv3.
    always_comb begin
        cur_port  = 3'd3;
        last_port = 1'b0;
        if (pass_idx == '0) begin
            last_port = (ptr == 2'd3);
            case (ptr)
                2'd0:    cur_port = 3'd1;
                2'd1:    cur_port = 3'd4;
                2'd2:    cur_port = 3'd2;
                default: cur_port = 3'd3;
            endcase
        end else begin
            last_port = (ptr == 2'd2);
            case (ptr)
                2'd0:    cur_port = 3'd5;
                2'd1:    cur_port = 3'd2;
                default: cur_port = 3'd3;
            endcase
        end
    end

    always_comb begin
        case (cur_port)
            3'd1:    wlast = WW'(W1_NUM - 1);
            3'd2:    wlast = WW'(W2_NUM - 1);
            3'd3:    wlast = WW'(W3_NUM - 1);
            3'd4:    wlast = WW'(W4_NUM - 1);
            default: wlast = WW'(W5_NUM - 1);
        endcase
    end

    assign busy              = (state != S_IDLE);
    assign weight_ready      = (state == S_LOAD);
    assign accept            = valid_weight_in & weight_ready;
    assign weight_out        = weight_in;
    assign valid_weight_out1 = accept & (cur_port == 3'd1);
    assign valid_weight_out2 = accept & (cur_port == 3'd2);
    assign valid_weight_out3 = accept & (cur_port == 3'd3);
    assign valid_weight_out4 = accept & (cur_port == 3'd4);
    assign valid_weight_out5 = accept & (cur_port == 3'd5);
    assign src_ready         = (state == S_RUN) & (pass_idx == '0);
    assign sel_feedback      = (pass_idx != '0);
    assign sel_shortcut      = (pass_idx != '0);
    assign last_pass_valid   = valid_add & (state == S_RUN) & (pass_idx == PASS_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            pass_idx <= '0;
            ptr      <= '0;
            wcnt     <= '0;
            pcnt     <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            // Adder beats are only meaningful in RUN; anywhere else they flag a protocol error.
            if (valid_add && state != S_RUN)
                err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        pass_idx <= '0;
                        ptr      <= '0;
                        wcnt     <= '0;
                        pcnt     <= '0;
                        err      <= valid_add;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (wcnt == wlast) begin
                            wcnt <= '0;
                            if (last_port) begin
                                ptr   <= '0;
                                state <= S_RUN;
                            end else begin
                                ptr <= ptr + 2'd1;
                            end
                        end else begin
                            wcnt <= wcnt + WW'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (valid_add) begin
                        if (pcnt == PCNT_LAST) begin
                            pcnt <= '0;
                            if (pass_idx == PASS_LAST) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                pass_idx <= pass_idx + PW'(1);
                                state    <= S_LOAD;
                            end
                        end else begin
                            pcnt <= pcnt + PCW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bottleneck_pass_sched.sv
// Randomized scoreboard bench for bottleneck_pass_sched: expected weight routing,
// last-pass flags and done pulses are queued at stimulus time and popped by a monitor.
module tb_bottleneck_pass_sched;

    localparam int NP   = 2;
    localparam int PXL  = 8;
    localparam int WN   = 4;
    localparam int LAST = NP - 1;

    typedef struct {
        int          port;
        logic [31:0] data;
    } wbeat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic [0:0]  pass_idx;
    logic        valid_weight_in = 1'b0;
    logic [31:0] weight_in = '0;
    logic        weight_ready;
    logic [31:0] weight_out;
    logic        vw1, vw2, vw3, vw4, vw5;
    logic        src_ready, sel_feedback, sel_shortcut;
    logic        valid_add = 1'b0;
    logic        last_pass_valid, err;

    int tests = 0;
    int fails = 0;
    bit exp_err = 0;
    int lpv_seen = 0;
    wbeat_t wq[$];
    int     lq[$];
    int     dq[$];

    bottleneck_pass_sched #(
        .DATA_WIDTH(32), .NUM_PASS(NP), .PXL_PER_PASS(PXL),
        .W1_NUM(WN), .W2_NUM(WN), .W3_NUM(WN), .W4_NUM(WN), .W5_NUM(WN)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .pass_idx(pass_idx), .valid_weight_in(valid_weight_in), .weight_in(weight_in),
        .weight_ready(weight_ready), .weight_out(weight_out),
        .valid_weight_out1(vw1), .valid_weight_out2(vw2), .valid_weight_out3(vw3),
        .valid_weight_out4(vw4), .valid_weight_out5(vw5),
        .src_ready(src_ready), .sel_feedback(sel_feedback), .sel_shortcut(sel_shortcut),
        .valid_add(valid_add), .last_pass_valid(last_pass_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe, flag or done pulse.
    always @(negedge clk) begin
        logic [4:0] s;
        int port;
        wbeat_t e;
        s = {vw5, vw4, vw3, vw2, vw1};
        if (s != 0) begin
            port = 0;
            for (int k = 0; k < 5; k++) if (s[k]) port = k + 1;
            chk("strobe_onehot", $countones(s), 1);
            if (wq.size() == 0) begin
                chk("unexpected_strobe", port, 0);
            end else begin
                e = wq.pop_front();
                chk("wport", port, e.port);
                chk("wdata", weight_out, e.data);
            end
        end
        if (last_pass_valid) begin
            if (lq.size() == 0) begin
                chk("unexpected_lpv", 1, 0);
            end else begin
                chk("lpv_seq", lpv_seen, lq.pop_front());
                chk("lpv_pass", pass_idx, LAST);
            end
            lpv_seen++;
        end
        if (done) begin
            if (dq.size() == 0) chk("unexpected_done", 1, 0);
            else void'(dq.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_err = 0;
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_err", err, 0);
        chk("start_pass", pass_idx, 0);
        chk("start_ready", weight_ready, 1);
        tick();
    endtask

    task automatic load_pass(input int p, input bit toggle, input bit seq_data, input bit inject_add);
        int order[$];
        int n = 0;
        logic [31:0] d;
        if (p == 0) order = '{1, 4, 2, 3};
        else        order = '{5, 2, 3};
        foreach (order[k]) begin
            for (int b = 0; b < WN; b++) begin
                if (toggle) tick();
                d = seq_data ? 32'(n) : $urandom;
                wq.push_back('{order[k], d});
                valid_weight_in = 1'b1;
                weight_in = d;
                if (inject_add && n == 5) begin
                    valid_add = 1'b1;
                    exp_err = 1;
                end
                @(negedge clk);
                chk("load_ready", weight_ready, 1);
                chk("load_pass", pass_idx, p);
                chk("load_selfb", sel_feedback, p != 0);
                chk("load_selsc", sel_shortcut, p != 0);
                tick();
                valid_weight_in = 1'b0;
                valid_add = 1'b0;
                n++;
            end
        end
        @(negedge clk);
        chk("run_ready", weight_ready, 0);
        chk("run_busy", busy, 1);
        chk("run_src", src_ready, p == 0);
        chk("run_err", err, exp_err);
        tick();
    endtask

    task automatic run_pass(input int p, input int nbeats, input bit stray);
        for (int i = 0; i < nbeats; i++) begin
            repeat ($urandom_range(0, 2)) begin
                if (stray) begin
                    valid_weight_in = $urandom_range(0, 1);
                    weight_in = $urandom;
                end
                @(negedge clk);
                chk("run_noready", weight_ready, 0);
                tick();
                valid_weight_in = 1'b0;
            end
            valid_add = 1'b1;
            if (p == LAST) lq.push_back(lpv_seen + lq.size());
            if (p == LAST && i == PXL - 1) dq.push_back(1);
            @(negedge clk);
            chk("run_src", src_ready, p == 0);
            chk("run_pass", pass_idx, p);
            tick();
            valid_add = 1'b0;
        end
        if (nbeats == PXL) begin
            @(negedge clk);
            if (p < LAST) begin
                chk("next_pass", pass_idx, p + 1);
                chk("next_ready", weight_ready, 1);
                chk("next_selfb", sel_feedback, 1);
                chk("next_selsc", sel_shortcut, 1);
                chk("next_src", src_ready, 0);
                tick();
            end else begin
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 1);
                tick();
                @(negedge clk);
                chk("done_clear", done, 0);
                chk("idle_busy", busy, 0);
                chk("idle_pass", pass_idx, LAST);
                chk("idle_err", err, exp_err);
                tick();
            end
        end
    endtask

    task automatic full_run(input bit toggle, input bit seq_data, input bit stray, input bit inject);
        do_start();
        load_pass(0, toggle, seq_data, 1'b0);
        run_pass(0, PXL, stray);
        load_pass(1, toggle, seq_data, inject);
        run_pass(1, PXL, stray);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass_idx, 0);
        chk("rst_ready", weight_ready, 0);
        chk("rst_err", err, 0);
        chk("rst_src", src_ready, 0);
        chk("rst_sel", sel_feedback, 0);
        tick();

        full_run(1'b0, 1'b1, 1'b0, 1'b0);
        full_run(1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("err_sticky_idle", err, 1);
        tick();

        // Abandon a pass mid-run; a start during RUN must be ignored.
        do_start();
        load_pass(0, 1'b0, 1'b0, 1'b0);
        run_pass(0, 3, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("start_in_run_pass", pass_idx, 0);
        chk("start_in_run_src", src_ready, 1);
        chk("start_in_run_ready", weight_ready, 0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_pass", pass_idx, 0);
        chk("abort_err", err, 0);
        tick();

        full_run(1'b0, 1'b1, 1'b0, 1'b0);
        repeat ($urandom_range(2, 5)) tick();
        for (int r = 0; r < 2; r++) full_run(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);

        repeat (2) tick();
        chk("wq_empty", wq.size(), 0);
        chk("lq_empty", lq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
